alu_branch_unit: RTL and testbench

Execute-stage block of the RV32I core. It decodes the main-control ALUOp plus funct3/funct7 into a 4-bit ALU operation and performs the 32-bit arithmetic, logic, shift or compare. It also resolves the branch/jump redirect decision from the ALU zero flag. Results are captured in a single output register stage, one cycle after the operands are presented.

---
 rtl/alu_branch_unit.sv | 124 ++++++++++++
 tb/tb_alu_branch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_branch_unit.sv
// alu_branch_unit: RV32I execute stage, ALU decode/compute plus branch/jump redirect, one register stage.
// Define ALU_SHIFT_EN to include the barrel shifter; without it shift ops yield 0.
module alu_branch_unit (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_valid,
  input  logic [2:0]  i_alu_op,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic        i_branch,
  input  logic        i_jump,
  output logic        o_valid,
  output logic [3:0]  o_alu_ctrl,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic [1:0]  o_bj_result
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_PASS = 4'b1010;

  logic [3:0]  w_alu_ctrl;
  logic [3:0]  w_ri_ctrl;
  logic [3:0]  w_br_ctrl;
  logic [31:0] w_result;
  logic        w_zero;
  logic        w_taken;
  logic [1:0]  w_bj;
  logic        w_f7b5;
  logic        w_rtype;

  assign w_f7b5  = i_funct7[5];
  assign w_rtype = (i_alu_op == 3'b010);

  // funct7[5] picks SUB only for R-type, but picks SRA for both R- and I-type
  always_comb begin
    w_ri_ctrl = OP_ADD;
    case (i_funct3)
      3'b000:  w_ri_ctrl = (w_rtype && w_f7b5) ? OP_SUB : OP_ADD;
      3'b001:  w_ri_ctrl = OP_SLL;
      3'b010:  w_ri_ctrl = OP_SLT;
      3'b011:  w_ri_ctrl = OP_SLTU;
      3'b100:  w_ri_ctrl = OP_XOR;
      3'b101:  w_ri_ctrl = w_f7b5 ? OP_SRA : OP_SRL;
      3'b110:  w_ri_ctrl = OP_OR;
      default: w_ri_ctrl = OP_AND;
    endcase
  end

  assign w_br_ctrl = (i_funct3[2:1] == 2'b10) ? OP_SLT :
                     (i_funct3[2:1] == 2'b11) ? OP_SLTU : OP_SUB;

  always_comb begin
    w_alu_ctrl = OP_ADD;
    case (i_alu_op)
      3'b001:  w_alu_ctrl = w_br_ctrl;
      3'b010,
      3'b011:  w_alu_ctrl = w_ri_ctrl;
      3'b100:  w_alu_ctrl = OP_PASS;
      default: w_alu_ctrl = OP_ADD;
    endcase
  end

  always_comb begin
    w_result = 32'h0;
    case (w_alu_ctrl)
      OP_AND:  w_result = i_op1 & i_op2;
      OP_OR:   w_result = i_op1 | i_op2;
      OP_ADD:  w_result = i_op1 + i_op2;
      OP_XOR:  w_result = i_op1 ^ i_op2;
`ifdef ALU_SHIFT_EN
      OP_SLL:  w_result = i_op1 << i_op2[4:0];
      OP_SRL:  w_result = i_op1 >> i_op2[4:0];
      OP_SRA:  w_result = $unsigned($signed(i_op1) >>> i_op2[4:0]);
`endif
      OP_SUB:  w_result = i_op1 - i_op2;
      OP_SLT:  w_result = {31'h0, $signed(i_op1) < $signed(i_op2)};
      OP_SLTU: w_result = {31'h0, i_op1 < i_op2};
      OP_PASS: w_result = i_op2;
      default: w_result = 32'h0;
    endcase
  end

  assign w_zero = (w_result == 32'h0);

  always_comb begin
    w_taken = 1'b0;
    case (i_funct3)
      3'b000, 3'b101, 3'b111: w_taken = w_zero;
      3'b001, 3'b100, 3'b110: w_taken = !w_zero;
      default:                w_taken = 1'b0;
    endcase
  end

  assign w_bj = {i_jump, (i_branch && w_taken) || i_jump};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid     <= 1'b0;
      o_alu_ctrl  <= 4'h0;
      o_result    <= 32'h0;
      o_zero      <= 1'b0;
      o_bj_result <= 2'b00;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_alu_ctrl  <= w_alu_ctrl;
        o_result    <= w_result;
        o_zero      <= w_zero;
        o_bj_result <= w_bj;
      end
    end
  end
endmodule

// File: tb/tb_alu_branch_unit.sv
// tb_alu_branch_unit: directed vector table plus reset/hold/jump sequences for alu_branch_unit.
module tb_alu_branch_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic [2:0]  alu_op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        br;
  logic        jmp;
  logic        o_valid;
  logic [3:0]  o_ctrl;
  logic [31:0] o_result;
  logic        o_zero;
  logic [1:0]  o_bj;
  int total = 0;
  int bad = 0;

  alu_branch_unit dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_alu_op(alu_op),
    .i_funct3(f3), .i_funct7(f7), .i_op1(op1), .i_op2(op2),
    .i_branch(br), .i_jump(jmp), .o_valid(o_valid), .o_alu_ctrl(o_ctrl),
    .o_result(o_result), .o_zero(o_zero), .o_bj_result(o_bj)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  alu_op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        br;
    logic        jmp;
    logic [31:0] res;
    logic [3:0]  ctrl;
    logic [1:0]  bj;
  } vec_t;

  vec_t v[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vl, input logic [2:0] a, input logic [2:0] fa, input logic [6:0] fb,
                       input logic [31:0] x, input logic [31:0] y, input logic b, input logic j);
    valid = vl; alu_op = a; f3 = fa; f7 = fb; op1 = x; op2 = y; br = b; jmp = j;
  endtask

  task automatic add(input string n, input logic [2:0] a, input logic [2:0] fa, input logic [6:0] fb,
                     input logic [31:0] x, input logic [31:0] y, input logic b, input logic j,
                     input logic [31:0] r, input logic [3:0] c, input logic [1:0] bj);
    vec_t e;
    e.name = n; e.alu_op = a; e.f3 = fa; e.f7 = fb; e.op1 = x; e.op2 = y;
    e.br = b; e.jmp = j; e.res = r; e.ctrl = c; e.bj = bj;
    v.push_back(e);
  endtask

  initial begin
    logic [31:0] sra_exp, srl_exp, sll_exp;
`ifdef ALU_SHIFT_EN
    sra_exp = 32'hF8000000; srl_exp = 32'h08000000; sll_exp = 32'h2;
`else
    sra_exp = 32'h0; srl_exp = 32'h0; sll_exp = 32'h0;
`endif
    add("add_ld",   3'b000, 3'b000, 7'h00, 32'd5,        32'd7,        0, 0, 32'd12,       4'b0010, 2'b00);
    add("r_sub",    3'b010, 3'b000, 7'h20, 32'd3,        32'd3,        0, 0, 32'd0,        4'b0110, 2'b00);
    add("r_add",    3'b010, 3'b000, 7'h00, 32'd3,        32'd3,        0, 0, 32'd6,        4'b0010, 2'b00);
    add("i_sra",    3'b011, 3'b101, 7'h20, 32'h80000000, 32'd4,        0, 0, sra_exp,      4'b1001, 2'b00);
    add("i_srl",    3'b011, 3'b101, 7'h00, 32'h80000000, 32'd4,        0, 0, srl_exp,      4'b0101, 2'b00);
    add("r_sll",    3'b010, 3'b001, 7'h00, 32'd1,        32'd33,       0, 0, sll_exp,      4'b0100, 2'b00);
    add("blt",      3'b001, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd1,        1, 0, 32'd1,        4'b0111, 2'b01);
    add("bltu",     3'b001, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd1,        1, 0, 32'd0,        4'b1000, 2'b00);
    add("bne",      3'b001, 3'b001, 7'h00, 32'd9,        32'd9,        1, 0, 32'd0,        4'b0110, 2'b00);
    add("bge",      3'b001, 3'b101, 7'h00, 32'd9,        32'd9,        1, 0, 32'd0,        4'b0111, 2'b01);
    add("beq_nt",   3'b001, 3'b000, 7'h00, 32'd4,        32'd5,        1, 0, 32'hFFFFFFFF, 4'b0110, 2'b00);
    add("br_f3_010",3'b001, 3'b010, 7'h00, 32'd7,        32'd7,        1, 0, 32'd0,        4'b0110, 2'b00);
    add("lui",      3'b100, 3'b000, 7'h00, 32'hDEADBEEF, 32'h12345000, 0, 0, 32'h12345000, 4'b1010, 2'b00);
    add("i_sltu",   3'b011, 3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 0, 0, 32'd1,        4'b1000, 2'b00);
    add("r_xor",    3'b010, 3'b100, 7'h00, 32'hF0F0,     32'h0FF0,     0, 0, 32'hFF00,     4'b0011, 2'b00);
    add("i_or",     3'b011, 3'b110, 7'h00, 32'hF0,       32'h0F,       0, 0, 32'hFF,       4'b0001, 2'b00);
    add("r_and",    3'b010, 3'b111, 7'h00, 32'hFF00,     32'h0FF0,     0, 0, 32'h0F00,     4'b0000, 2'b00);
    add("i_add_f7", 3'b011, 3'b000, 7'h20, 32'd10,       32'd3,        0, 0, 32'd13,       4'b0010, 2'b00);
    add("r_slt_f7", 3'b010, 3'b010, 7'h1F, 32'hFFFFFFFB, 32'd3,        0, 0, 32'd1,        4'b0111, 2'b00);
    add("aluop111", 3'b111, 3'b011, 7'h20, 32'd2,        32'd3,        0, 0, 32'd5,        4'b0010, 2'b00);
    add("add_wrap", 3'b000, 3'b000, 7'h00, 32'hFFFFFFFF, 32'd1,        0, 0, 32'd0,        4'b0010, 2'b00);
    add("jmp_br",   3'b000, 3'b001, 7'h00, 32'd1,        32'd1,        1, 1, 32'd2,        4'b0010, 2'b11);

    rstn = 1'b0;
    drive(1, 3'b010, 3'b000, 7'h20, 32'd77, 32'd11, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  {31'h0, o_valid}, 32'h0);
    check("rst_ctrl",   {28'h0, o_ctrl},  32'h0);
    check("rst_result", o_result,         32'h0);
    check("rst_zero",   {31'h0, o_zero},  32'h0);
    check("rst_bj",     {30'h0, o_bj},    32'h0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (v[i]) begin
      drive(1, v[i].alu_op, v[i].f3, v[i].f7, v[i].op1, v[i].op2, v[i].br, v[i].jmp);
      @(posedge clk);
      #1;
      check({v[i].name, "_res"},   o_result,          v[i].res);
      check({v[i].name, "_ctrl"},  {28'h0, o_ctrl},   {28'h0, v[i].ctrl});
      check({v[i].name, "_zero"},  {31'h0, o_zero},   {31'h0, v[i].res == 32'h0});
      check({v[i].name, "_bj"},    {30'h0, o_bj},     {30'h0, v[i].bj});
      check({v[i].name, "_valid"}, {31'h0, o_valid},  32'h1);
    end

    // jump, then an idle cycle: outputs other than o_valid must hold
    drive(1, 3'b000, 3'b000, 7'h00, 32'h100, 32'h20, 0, 1);
    @(posedge clk);
    #1;
    check("jmp_bj", {30'h0, o_bj}, 32'h3);
    drive(0, 3'b010, 3'b000, 7'h20, 32'd5, 32'd5, 1, 0);
    @(posedge clk);
    #1;
    check("idle_valid",  {31'h0, o_valid}, 32'h0);
    check("idle_bj",     {30'h0, o_bj},    32'h3);
    check("idle_result", o_result,         32'h120);
    check("idle_ctrl",   {28'h0, o_ctrl},  32'h2);
    check("idle_zero",   {31'h0, o_zero},  32'h0);

    // a valid non-redirecting op clears the redirect
    drive(1, 3'b000, 3'b000, 7'h00, 32'd1, 32'd2, 0, 0);
    @(posedge clk);
    #1;
    check("clr_bj",  {30'h0, o_bj}, 32'h0);
    check("clr_res", o_result,      32'd3);

    // asynchronous reset mid-cycle drops the captured result at once
    drive(1, 3'b001, 3'b000, 7'h00, 32'd6, 32'd6, 1, 0);
    @(posedge clk);
    #1;
    check("pre_rst_bj", {30'h0, o_bj}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_valid",  {31'h0, o_valid}, 32'h0);
    check("async_bj",     {30'h0, o_bj},    32'h0);
    check("async_zero",   {31'h0, o_zero},  32'h0);
    check("async_ctrl",   {28'h0, o_ctrl},  32'h0);
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 3'b000, 3'b000, 7'h00, 32'd5, 32'd7, 0, 0);
    @(posedge clk);
    #1;
    check("post_rst_res",   o_result,         32'd12);
    check("post_rst_valid", {31'h0, o_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
